// File: rtl/fft_mag_writer.sv
// fft_mag_writer: write side of the FFT-magnitude buffer handshake.
// Converts each streamed complex bin into |re|+|im| (saturated to DATA_W bits)
// and writes one full frame into BRAM port A. The frame is then held, with
// wubs_done high, until the reader returns FFT_done. Frames that arrive while
// the buffer is held are discarded and counted.
//
// Stream handshake: a beat transfers on a rising clock edge where
// fft_valid && fft_ready. fft_ready is low only while in reset, so the
// producer is never stalled. Beats that arrive outside FILL are discarded
// but still count as transferred.
module fft_mag_writer #(
  parameter int N_BINS = 1024,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic signed [DATA_W-1:0] fft_re,
  input  logic signed [DATA_W-1:0] fft_im,
  input  logic                     fft_valid,
  input  logic                     fft_last,
  output logic                     fft_ready,
  output logic [ADDR_W-1:0]        addr2_a,
  output logic [DATA_W-1:0]        din2_a,
  output logic                     we2_a,
  output logic                     wubs_done,
  input  logic                     FFT_done,
  output logic [7:0]               frames_dropped,
  output logic                     frame_err,
  output logic [1:0]               state_dbg
);

  typedef enum logic [1:0] {
    S_SYNC = 2'd0,
    S_FILL = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_BINS - 1);
  localparam logic [DATA_W:0]   ONE_W1   = {{DATA_W{1'b0}}, 1'b1};

  state_t              state_q;
  logic [ADDR_W-1:0]   idx_q;
  logic                ready_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   din_q;
  logic                we_q;
  logic                done_q;
  logic [7:0]          drop_q;
  logic                err_q;

  logic                beat;
  logic [DATA_W:0]     abs_re;
  logic [DATA_W:0]     abs_im;
  logic [DATA_W:0]     mag_sum;
  logic [DATA_W-1:0]   mag;

  assign beat = fft_valid && ready_q;

  // Magnitude |re|+|im| in DATA_W+1 bits so abs(most-negative) is exact; the
  // only out-of-range sum (both parts most-negative) saturates to all-ones.
  always_comb begin
    abs_re  = fft_re[DATA_W-1] ? ({1'b0, ~fft_re} + ONE_W1) : {1'b0, fft_re};
    abs_im  = fft_im[DATA_W-1] ? ({1'b0, ~fft_im} + ONE_W1) : {1'b0, fft_im};
    mag_sum = abs_re + abs_im;
    mag     = mag_sum[DATA_W] ? {DATA_W{1'b1}} : mag_sum[DATA_W-1:0];
  end

  // Frame FSM with registered BRAM port, done level, drop counter and error flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_SYNC;
      idx_q   <= '0;
      ready_q <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      we_q    <= 1'b0;
      case (state_q)
        S_SYNC: begin
          // Discard until a frame boundary so the next beat is bin 0.
          if (beat && fft_last) begin
            state_q <= S_FILL;
            idx_q   <= '0;
          end
        end
        S_FILL: begin
          if (beat) begin
            we_q   <= 1'b1;
            addr_q <= idx_q;
            din_q  <= mag;
            if (fft_last) begin
              idx_q <= '0;
              if (idx_q == LAST_IDX) begin
                state_q <= S_HOLD;
              end else begin
                // Short frame: restart filling, never signal done for it.
                err_q <= 1'b1;
              end
            end else if (idx_q == LAST_IDX) begin
              // Long frame: boundary lost, resynchronise on the next fft_last.
              err_q   <= 1'b1;
              idx_q   <= '0;
              state_q <= S_SYNC;
            end else begin
              idx_q <= idx_q + ADDR_W'(1);
            end
          end
        end
        S_HOLD: begin
          // done rises one cycle after entry, i.e. after the final write lands.
          done_q <= 1'b1;
          if (beat && fft_last && (drop_q != 8'hFF)) begin
            drop_q <= drop_q + 8'd1;
          end
          if (FFT_done) begin
            done_q <= 1'b0;
            if (beat && fft_last) begin
              // Boundary seen in the same cycle: fill the next frame directly.
              state_q <= S_FILL;
              idx_q   <= '0;
            end else begin
              state_q <= S_SYNC;
            end
          end
        end
        default: state_q <= S_SYNC;
      endcase
    end
  end

  assign fft_ready      = ready_q;
  assign addr2_a        = addr_q;
  assign din2_a         = din_q;
  assign we2_a          = we_q;
  assign wubs_done      = done_q;
  assign frames_dropped = drop_q;
  assign frame_err      = err_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_fft_mag_writer.sv
`timescale 1ns/1ps
// tb_fft_mag_writer: directed stream frames against a write scoreboard.
module tb_fft_mag_writer;

  logic        clock;
  logic        reset_n;
  logic [15:0] fft_re;
  logic [15:0] fft_im;
  logic        fft_valid;
  logic        fft_last;
  logic        fft_ready;
  logic [9:0]  addr2_a;
  logic [15:0] din2_a;
  logic        we2_a;
  logic        wubs_done;
  logic        FFT_done;
  logic [7:0]  frames_dropped;
  logic        frame_err;
  logic [1:0]  state_dbg;

  int tests_run;
  int tests_failed;
  logic [25:0] exp_q[$];

  fft_mag_writer #(.N_BINS(1024), .ADDR_W(10), .DATA_W(16)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .fft_re         (fft_re),
    .fft_im         (fft_im),
    .fft_valid      (fft_valid),
    .fft_last       (fft_last),
    .fft_ready      (fft_ready),
    .addr2_a        (addr2_a),
    .din2_a         (din2_a),
    .we2_a          (we2_a),
    .wubs_done      (wubs_done),
    .FFT_done       (FFT_done),
    .frames_dropped (frames_dropped),
    .frame_err      (frame_err),
    .state_dbg      (state_dbg)
  );

  // Clock and watchdog
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver: one beat presented for exactly one clock edge; returns 1 ns after it.
  task automatic send(input logic [15:0] re, input logic [15:0] im, input logic last,
                      input logic wr, input logic [9:0] a, input logic [15:0] d,
                      input logic dn);
    @(negedge clock);
    fft_valid = 1'b1;
    fft_re    = re;
    fft_im    = im;
    fft_last  = last;
    FFT_done  = dn;
    if (wr) exp_q.push_back({a, d});
    @(posedge clock);
    #1;
    fft_valid = 1'b0;
    fft_last  = 1'b0;
    FFT_done  = 1'b0;
  endtask

  // Scoreboard monitor: every BRAM write must match the oldest expected write.
  always @(negedge clock) begin
    if (reset_n && we2_a) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_write: addr=%0d din=%0h with no write expected", addr2_a, din2_a);
      end else begin
        logic [25:0] e;
        e = exp_q.pop_front();
        if ({addr2_a, din2_a} !== e) begin
          tests_failed++;
          $display("FAIL write: addr=%0d din=%0h expected addr=%0d din=%0h",
                   addr2_a, din2_a, e[25:16], e[15:0]);
        end
      end
    end
  end

  logic [15:0] sp_re[6];
  logic [15:0] sp_im[6];
  logic [15:0] sp_mag[6];

  initial begin
    tests_run = 0; tests_failed = 0;
    reset_n = 1'b0; fft_valid = 1'b0; fft_last = 1'b0; FFT_done = 1'b0;
    fft_re = '0; fft_im = '0;
    sp_re[0] = 16'h8000; sp_im[0] = 16'h8000; sp_mag[0] = 16'hFFFF;
    sp_re[1] = 16'h8000; sp_im[1] = 16'h0000; sp_mag[1] = 16'h8000;
    sp_re[2] = 16'h0000; sp_im[2] = 16'h0000; sp_mag[2] = 16'h0000;
    sp_re[3] = 16'h7FFF; sp_im[3] = 16'h7FFF; sp_mag[3] = 16'hFFFE;
    sp_re[4] = 16'hFFFF; sp_im[4] = 16'h0001; sp_mag[4] = 16'h0002;
    sp_re[5] = 16'h8001; sp_im[5] = 16'h7FFF; sp_mag[5] = 16'hFFFE;

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_ready", fft_ready, 0);
    chk("rst_we", we2_a, 0);
    chk("rst_done", wubs_done, 0);
    chk("rst_addr", addr2_a, 0);
    chk("rst_din", din2_a, 0);
    chk("rst_drop", frames_dropped, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_state", state_dbg, 0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("ready_after_rst", fft_ready, 1);

    // Two dummy beats then a last: discarded, exits SYNC
    send(16'd1, 16'd1, 1'b0, 1'b0, 10'd0, 16'd0, 1'b0);
    send(16'd1, 16'd1, 1'b0, 1'b0, 10'd0, 16'd0, 1'b0);
    send(16'd1, 16'd1, 1'b1, 1'b0, 10'd0, 16'd0, 1'b0);

    // Frame 1: re=3, im=-4 -> 7 at addr 0..1023
    for (int i = 0; i < 1024; i++)
      send(16'd3, 16'hFFFC, (i == 1023), 1'b1, 10'(i), 16'd7, 1'b0);
    @(negedge clock);
    chk("done_t1_low", wubs_done, 0);
    @(negedge clock);
    chk("done_t2_high", wubs_done, 1);

    // Three full frames while held: no writes, all counted as dropped
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < 1024; i++)
        send(16'd9, 16'd9, (i == 1023), 1'b0, 10'd0, 16'd0, 1'b0);
    @(negedge clock);
    chk("drop_3", frames_dropped, 3);
    chk("done_still_held", wubs_done, 1);

    // FFT_done mid-frame: buffer freed, rest of that frame discarded
    for (int i = 0; i < 1024; i++) begin
      send(16'd5, 16'd5, (i == 1023), 1'b0, 10'd0, 16'd0, (i == 100));
      if (i == 100) begin
        @(negedge clock);
        chk("done_release", wubs_done, 0);
      end
    end
    @(negedge clock);
    chk("drop_unchanged_in_sync", frames_dropped, 3);

    // Next frame from addr 0 with magnitude corner cases first
    for (int i = 0; i < 1024; i++) begin
      if (i < 6) send(sp_re[i], sp_im[i], 1'b0, 1'b1, 10'(i), sp_mag[i], 1'b0);
      else       send(16'd3, 16'hFFFC, (i == 1023), 1'b1, 10'(i), 16'd7, 1'b0);
    end
    repeat (2) @(negedge clock);
    chk("done_frame3", wubs_done, 1);
    chk("err_clean", frame_err, 0);
    FFT_done = 1'b1;
    @(posedge clock); #1; FFT_done = 1'b0;
    @(negedge clock);
    chk("done_release_idle", wubs_done, 0);

    // Resync, then short frame ending at bin 500
    send(16'd1, 16'd1, 1'b1, 1'b0, 10'd0, 16'd0, 1'b0);
    for (int i = 0; i <= 500; i++)
      send(16'd3, 16'hFFFC, (i == 500), 1'b1, 10'(i), 16'd7, 1'b0);
    repeat (2) @(negedge clock);
    chk("short_err", frame_err, 1);
    chk("short_no_done", wubs_done, 0);

    // Gapped valid (1 of 3 cycles): contiguous addresses from 0, re=-20 im=100
    for (int i = 0; i < 1024; i++) begin
      repeat (2) @(negedge clock);
      send(16'hFFEC, 16'd100, (i == 1023), 1'b1, 10'(i), 16'd120, 1'b0);
    end
    repeat (2) @(negedge clock);
    chk("gap_done", wubs_done, 1);
    chk("err_sticky", frame_err, 1);

    // FFT_done coincident with a discarded last: counted, fill restarts directly
    for (int i = 0; i < 4; i++)
      send(16'd2, 16'd2, 1'b0, 1'b0, 10'd0, 16'd0, 1'b0);
    send(16'd2, 16'd2, 1'b1, 1'b0, 10'd0, 16'd0, 1'b1);
    @(negedge clock);
    chk("coinc_drop", frames_dropped, 4);
    chk("coinc_done_low", wubs_done, 0);
    for (int i = 0; i < 10; i++)
      send(16'd1, 16'd1, 1'b0, 1'b1, 10'(i), 16'd2, 1'b0);

    // Reset mid-FILL: outputs clear immediately
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_we", we2_a, 0);
    chk("midrst_ready", fft_ready, 0);
    chk("midrst_addr", addr2_a, 0);
    chk("midrst_din", din2_a, 0);
    chk("midrst_drop", frames_dropped, 0);
    chk("midrst_err", frame_err, 0);
    chk("midrst_done", wubs_done, 0);
    chk("pending_writes", exp_q.size(), 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // Re-sync required: non-last beat discarded, last exits SYNC
    send(16'd4, 16'd4, 1'b0, 1'b0, 10'd0, 16'd0, 1'b0);
    send(16'd4, 16'd4, 1'b1, 1'b0, 10'd0, 16'd0, 1'b0);
    send(16'd0, 16'd9, 1'b0, 1'b1, 10'd0, 16'd9, 1'b0);
    send(16'd0, 16'hFFF7, 1'b0, 1'b1, 10'd1, 16'd9, 1'b0);
    repeat (3) @(negedge clock);
    chk("final_pending", exp_q.size(), 0);
    chk("final_err", frame_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
